// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg: opcode constants, the decoded bundle type, the bubble
// constant and the field decoder shared by the decode/issue stage.
// Optional feature macro: DECODE_REG_BYPASS_EN (used by the regfile and top).
package decode_issue_pkg;

    localparam int          NREG     = 64;          // idx[5]=0 GPR, idx[5]=1 FPR
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // op_type classes (word bits [31:30])
    localparam logic [1:0] OPT_ALU  = 2'd0;
    localparam logic [1:0] OPT_IMM  = 2'd1;
    localparam logic [1:0] OPT_MEM  = 2'd2;
    localparam logic [1:0] OPT_CTRL = 2'd3;

    // ALU / FPU function codes (instr field under OPT_ALU); all read rs and rt
    localparam logic [3:0] FUNC_ADD = 4'd0;
    localparam logic [3:0] FUNC_SUB = 4'd1;
    localparam logic [3:0] FUNC_AND = 4'd2;
    localparam logic [3:0] FUNC_OR  = 4'd3;
    localparam logic [3:0] FPU_ADD  = 4'd8;
    localparam logic [3:0] FPU_MUL  = 4'd9;

    // Full opcodes {op_type, instr}
    localparam logic [5:0] OP_ADD  = {OPT_ALU,  FUNC_ADD};
    localparam logic [5:0] OP_ADDI = {OPT_IMM,  4'd0};
    localparam logic [5:0] OP_LUI  = {OPT_IMM,  4'd1};
    localparam logic [5:0] OP_LI   = {OPT_IMM,  4'd2};
    localparam logic [5:0] OP_LW   = {OPT_MEM,  4'd0};
    localparam logic [5:0] OP_SW   = {OPT_MEM,  4'd1};
    localparam logic [5:0] OP_LW_S = {OPT_MEM,  4'd2};
    localparam logic [5:0] OP_SW_S = {OPT_MEM,  4'd3};
    localparam logic [5:0] OP_OUT  = {OPT_MEM,  4'd4};
    localparam logic [5:0] OP_IN   = {OPT_MEM,  4'd5};
    localparam logic [5:0] OP_J    = {OPT_CTRL, 4'd0};
    localparam logic [5:0] OP_JAL  = {OPT_CTRL, 4'd1};
    localparam logic [5:0] OP_BEQ  = {OPT_CTRL, 4'd2};
    localparam logic [5:0] OP_BNE  = {OPT_CTRL, 4'd3};
    localparam logic [5:0] OP_JR   = {OPT_CTRL, 4'd4};

    // Decode->execute bundle (operand values live beside it in the top)
    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  op_type;
        logic [3:0]  instr;
        logic [6:0]  rs;       // {reads_flag, idx}
        logic [6:0]  rt;       // {reads_flag, idx}
        logic [5:0]  rd;
        logic [31:0] imm;
        logic        branch;
        logic        jump;
        logic        is_jr;
    } decoded_t;

    // What the stage does on the coming edge, in priority order
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_FLUSH,
        ACT_STALL,
        ACT_ISSUE,
        ACT_IDLE
    } action_e;

    function automatic decoded_t decode(input logic [31:0] w, input logic [31:0] pc);
        decoded_t   d;
        logic       rd_s;
        logic       rd_t;
        logic [5:0] op;
        d       = '0;
        rd_s    = 1'b0;
        rd_t    = 1'b0;
        op      = w[31:26];
        d.pc      = pc;
        d.op_type = w[31:30];
        d.instr   = w[29:26];
        d.rd      = w[13:8];
        d.imm     = {{16{w[15]}}, w[15:0]};
        if (w[31:30] == OPT_ALU) begin
            rd_s = 1'b1;
            rd_t = 1'b1;
        end else begin
            case (op)
                OP_ADDI:                rd_s = 1'b1;
                OP_LUI, OP_LI:          d.imm = {16'h0000, w[15:0]};
                OP_LW, OP_LW_S, OP_OUT: rd_s = 1'b1;
                OP_SW, OP_SW_S: begin
                    rd_s = 1'b1;
                    rd_t = 1'b1;
                end
                OP_J, OP_JAL: begin
                    d.jump = 1'b1;
                    d.imm  = {6'b000000, w[25:0]};
                end
                OP_BEQ, OP_BNE: begin
                    d.branch = 1'b1;
                    rd_s     = 1'b1;
                    rd_t     = 1'b1;
                end
                OP_JR: begin
                    d.is_jr = 1'b1;
                    rd_s    = 1'b1;
                end
                default: ;
            endcase
        end
        d.rs = {rd_s, w[25:20]};
        d.rt = {rd_t, w[19:14]};
        return d;
    endfunction

    // The bubble is NOP_WORD with every flag (reads flags included) cleared.
    function automatic decoded_t make_bubble();
        decoded_t d;
        d        = decode(NOP_WORD, 32'h0000_0000);
        d.rs[6]  = 1'b0;
        d.rt[6]  = 1'b0;
        d.branch = 1'b0;
        d.jump   = 1'b0;
        d.is_jr  = 1'b0;
        return d;
    endfunction

    localparam decoded_t BUBBLE = make_bubble();

    // True when the decoded word actually reads register idx through rs or rt.
    function automatic logic reads_idx(input decoded_t d, input logic [5:0] idx);
        return (d.rs[6] && (d.rs[5:0] == idx)) || (d.rt[6] && (d.rt[5:0] == idx));
    endfunction

endpackage

// File: rtl/decode_issue_if.sv
// decode_issue_if: fetch, execute-feedback, writeback and decode->execute
// bundle signals of the decode/issue stage.
//   slave  : the decode_issue stage (consumes fetch/wb, drives if_ready and de_*)
//   master : the environment around it
interface decode_issue_if;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        ex_busy;
    logic        ex_redirect;
    logic        wb_we;
    logic [5:0]  wb_rd;
    logic [31:0] wb_d;
    logic [31:0] de_pc;
    logic [1:0]  de_op_type;
    logic [3:0]  de_instr;
    logic [31:0] de_s;
    logic [31:0] de_t;
    logic [6:0]  de_rs;
    logic [6:0]  de_rt;
    logic [5:0]  de_rd;
    logic [31:0] de_imm;
    logic        de_branch;
    logic        de_jump;
    logic        de_is_jr;
    logic        de_start;
    logic        de_hazard;

    modport slave (
        input  if_valid, if_pc, if_instr, ex_busy, ex_redirect, wb_we, wb_rd, wb_d,
        output if_ready, de_pc, de_op_type, de_instr, de_s, de_t, de_rs, de_rt,
               de_rd, de_imm, de_branch, de_jump, de_is_jr, de_start, de_hazard
    );

    modport master (
        output if_valid, if_pc, if_instr, ex_busy, ex_redirect, wb_we, wb_rd, wb_d,
        input  if_ready, de_pc, de_op_type, de_instr, de_s, de_t, de_rs, de_rt,
               de_rd, de_imm, de_branch, de_jump, de_is_jr, de_start, de_hazard
    );
endinterface

// File: rtl/decode_issue_regfile_2r1w.sv
// regfile_2r1w: NREG x 32 register file, two asynchronous read ports and one
// synchronous write port. Index 0 reads as zero and ignores writes.
// Macro DECODE_REG_BYPASS_EN: a read of the index being written this cycle
// returns the write data; otherwise it returns the stored (old) value.
// Ports: clk, rstn, i_we/i_wa/i_wd (write), i_ra0/i_ra1 -> o_rd0/o_rd1 (read).
module regfile_2r1w
    import decode_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_we,
    input  logic [5:0]  i_wa,
    input  logic [31:0] i_wd,
    input  logic [5:0]  i_ra0,
    input  logic [5:0]  i_ra1,
    output logic [31:0] o_rd0,
    output logic [31:0] o_rd1
);
    logic [31:0] r_mem [1:NREG-1];

    // NOTE: the array sits in the async reset because a cleared register file
    // is architecturally visible; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 1; i < NREG; i++) r_mem[i] <= '0;
        end else if (i_we && (i_wa != 6'd0)) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    function automatic logic [31:0] rd_port(input logic [5:0] ra);
        if (ra == 6'd0) return 32'h0000_0000;
`ifdef DECODE_REG_BYPASS_EN
        if (i_we && (i_wa == ra)) return i_wd;
`endif
        return r_mem[ra];
    endfunction

    always_comb begin
        o_rd0 = rd_port(i_ra0);
        o_rd1 = rd_port(i_ra1);
    end
endmodule

// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage ahead of execute. Decodes the fetched word,
// reads the register file and registers the de_* bundle one cycle later.
// Holds on ex_busy, squashes on ex_redirect, inserts a hazard bubble on
// load-use (and, without DECODE_REG_BYPASS_EN, on a same-cycle wb read clash).
// Ports: clk, rstn (async active-low), bus (decode_issue_if.slave: if_*, ex_*,
// wb_* in; if_ready and de_* out).
module decode_issue
    import decode_issue_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    decode_issue_if.slave bus
);
    decoded_t    w_dec;
    logic [31:0] w_s;
    logic [31:0] w_t;
    logic        w_is_load;
    logic        w_load_use;
    logic        w_wb_clash;
    action_e     w_act;

    decoded_t    r_de;
    logic [31:0] r_s;
    logic [31:0] r_t;
    logic        r_start;
    logic        r_hazard;

    assign w_dec = decode(bus.if_instr, bus.if_pc);

    regfile_2r1w u_regfile (
        .clk   (clk),
        .rstn  (rstn),
        .i_we  (bus.wb_we),
        .i_wa  (bus.wb_rd),
        .i_wd  (bus.wb_d),
        .i_ra0 (w_dec.rs[5:0]),
        .i_ra1 (w_dec.rt[5:0]),
        .o_rd0 (w_s),
        .o_rd1 (w_t)
    );

    assign w_is_load  = ({r_de.op_type, r_de.instr} == OP_LW) ||
                        ({r_de.op_type, r_de.instr} == OP_LW_S);
    assign w_load_use = w_is_load && reads_idx(w_dec, r_de.rd);

    // Without write-through the read would see stale data, so wait one cycle.
`ifdef DECODE_REG_BYPASS_EN
    assign w_wb_clash = 1'b0;
`else
    assign w_wb_clash = bus.wb_we && reads_idx(w_dec, bus.wb_rd);
`endif

    // NOTE: w_act gets its default before the if-chain so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_act = ACT_IDLE;
        if (bus.ex_busy)                                   w_act = ACT_HOLD;
        else if (bus.ex_redirect)                          w_act = ACT_FLUSH;
        else if (bus.if_valid && (w_load_use || w_wb_clash)) w_act = ACT_STALL;
        else if (bus.if_valid)                             w_act = ACT_ISSUE;
    end

    // Consumed only on issue or on a redirect drop; forced low during reset.
    assign bus.if_ready = rstn && ((w_act == ACT_ISSUE) || (w_act == ACT_FLUSH));

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_de     <= '0;
            r_s      <= '0;
            r_t      <= '0;
            r_start  <= 1'b0;
            r_hazard <= 1'b0;
        end else begin
            case (w_act)
                ACT_HOLD: r_start <= 1'b0;   // bundle frozen, start already seen
                ACT_ISSUE: begin
                    r_de     <= w_dec;
                    r_s      <= w_s;
                    r_t      <= w_t;
                    r_start  <= 1'b1;
                    r_hazard <= 1'b0;
                end
                ACT_STALL: begin
                    r_de     <= BUBBLE;
                    r_s      <= '0;
                    r_t      <= '0;
                    r_start  <= 1'b0;
                    r_hazard <= 1'b1;
                end
                default: begin               // redirect squash or idle
                    r_de     <= BUBBLE;
                    r_s      <= '0;
                    r_t      <= '0;
                    r_start  <= 1'b0;
                    r_hazard <= 1'b0;
                end
            endcase
        end
    end

    assign bus.de_pc      = r_de.pc;
    assign bus.de_op_type = r_de.op_type;
    assign bus.de_instr   = r_de.instr;
    assign bus.de_s       = r_s;
    assign bus.de_t       = r_t;
    assign bus.de_rs      = r_de.rs;
    assign bus.de_rt      = r_de.rt;
    assign bus.de_rd      = r_de.rd;
    assign bus.de_imm     = r_de.imm;
    assign bus.de_branch  = r_de.branch;
    assign bus.de_jump    = r_de.jump;
    assign bus.de_is_jr   = r_de.is_jr;
    assign bus.de_start   = r_start;
    assign bus.de_hazard  = r_hazard;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed bench for decode_issue. A cycle-level model built
// from the stage's rules is compared against the DUT on every falling edge;
// literal expectations on each directed scenario pin the model itself.
// Honours DECODE_REG_BYPASS_EN the same way the design does.
module tb_decode_issue;
    import decode_issue_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    decode_issue_if bus ();
    decode_issue dut (.clk(clk), .rstn(rstn), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_f(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, {128'b0, act}, {128'b0, exp});
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0] m_rf [64];
    bit [31:0] m_pc, m_s, m_t, m_imm;
    bit [1:0]  m_ot;
    bit [3:0]  m_ins;
    bit [6:0]  m_rs, m_rt;
    bit [5:0]  m_rd;
    bit        m_br, m_jmp, m_jr, m_start, m_haz;

    // {reads_rs, reads_rt} per opcode
    function automatic bit [1:0] m_reads(input bit [31:0] w);
        if (w[31:30] == OPT_ALU) return 2'b11;
        case (w[31:26])
            OP_ADDI, OP_LW, OP_LW_S, OP_OUT, OP_JR: return 2'b10;
            OP_SW, OP_SW_S, OP_BEQ, OP_BNE:         return 2'b11;
            default:                                return 2'b00;
        endcase
    endfunction

    function automatic bit [31:0] m_imm_of(input bit [31:0] w);
        if (w[31:26] == OP_J || w[31:26] == OP_JAL) return {6'd0, w[25:0]};
        if (w[31:26] == OP_LUI || w[31:26] == OP_LI) return {16'd0, w[15:0]};
        return {{16{w[15]}}, w[15:0]};
    endfunction

    function automatic bit [31:0] m_read(input bit [5:0] idx);
        if (idx == 0) return 0;
`ifdef DECODE_REG_BYPASS_EN
        if (bus.wb_we && bus.wb_rd == idx) return bus.wb_d;
`endif
        return m_rf[idx];
    endfunction

    function automatic bit m_hits(input bit [31:0] w, input bit [5:0] idx);
        bit [1:0] r;
        r = m_reads(w);
        return (r[1] && w[25:20] == idx) || (r[0] && w[19:14] == idx);
    endfunction

    function automatic bit m_stall();
        bit lu;
        bit wbc;
        lu  = ({m_ot, m_ins} == OP_LW || {m_ot, m_ins} == OP_LW_S) && m_hits(bus.if_instr, m_rd);
        wbc = 1'b0;
`ifndef DECODE_REG_BYPASS_EN
        wbc = bus.wb_we && m_hits(bus.if_instr, bus.wb_rd);
`endif
        return lu || wbc;
    endfunction

    function automatic bit m_if_ready();
        if (!rstn)                      return 0;
        if (bus.ex_busy)                return 0;
        if (bus.ex_redirect)            return 1;
        if (bus.if_valid && m_stall())  return 0;
        return bus.if_valid;
    endfunction

    task automatic m_bubble(input bit h);
        {m_pc, m_s, m_t, m_imm, m_ot, m_ins, m_rs, m_rt, m_rd} = '0;
        {m_br, m_jmp, m_jr, m_start} = '0;
        m_haz = h;
    endtask

    task automatic m_issue();
        bit [31:0] w;
        bit [1:0]  r;
        w = bus.if_instr;
        r = m_reads(w);
        m_pc = bus.if_pc; m_ot = w[31:30]; m_ins = w[29:26];
        m_rs = {r[1], w[25:20]}; m_rt = {r[0], w[19:14]}; m_rd = w[13:8];
        m_imm = m_imm_of(w);
        m_s = m_read(w[25:20]); m_t = m_read(w[19:14]);
        m_br  = (w[31:26] == OP_BEQ || w[31:26] == OP_BNE);
        m_jmp = (w[31:26] == OP_J || w[31:26] == OP_JAL);
        m_jr  = (w[31:26] == OP_JR);
        m_start = 1; m_haz = 0;
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_bubble(0);
            for (int i = 0; i < 64; i++) m_rf[i] = 0;
        end else begin
            if (bus.ex_busy)                    m_start = 0;
            else if (bus.ex_redirect)           m_bubble(0);
            else if (bus.if_valid && m_stall()) m_bubble(1);
            else if (bus.if_valid)              m_issue();
            else                                m_bubble(0);
            if (bus.wb_we && bus.wb_rd != 0) m_rf[bus.wb_rd] = bus.wb_d;
        end
    end

    function automatic logic [159:0] dut_vec();
        return {bus.de_pc, bus.de_op_type, bus.de_instr, bus.de_s, bus.de_t, bus.de_rs,
                bus.de_rt, bus.de_rd, bus.de_imm, bus.de_branch, bus.de_jump, bus.de_is_jr,
                bus.de_start, bus.de_hazard, bus.if_ready};
    endfunction

    function automatic logic [159:0] model_vec();
        return {m_pc, m_ot, m_ins, m_s, m_t, m_rs, m_rt, m_rd, m_imm, m_br, m_jmp, m_jr,
                m_start, m_haz, m_if_ready()};
    endfunction

    always @(negedge clk) if (rstn) check("cycle_model", dut_vec(), model_vec());

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [5:0] rs,
                                          input logic [5:0] rt, input logic [5:0] rd);
        return {op, rs, rt, rd, 8'h00};
    endfunction

    // rd overlays imm[13:8] and rt overlays imm[15:14]
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [5:0] rs,
                                          input logic [15:0] imm);
        return {op, rs, 4'h0, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_valid = 0; bus.if_pc = 0; bus.if_instr = 0;
        bus.ex_busy = 0; bus.ex_redirect = 0;
        bus.wb_we = 0; bus.wb_rd = 0; bus.wb_d = 0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] w);
        bus.if_valid = 1; bus.if_pc = pc; bus.if_instr = w;
    endtask

    task automatic wb(input logic [5:0] rd, input logic [31:0] d);
        bus.wb_we = 1; bus.wb_rd = rd; bus.wb_d = d;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rstn = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_f("rst_pc", bus.de_pc, 32'h0);
        check_f("rst_ready", 32'(bus.if_ready), 32'd0);
        check_f("rst_start", 32'(bus.de_start), 32'd0);
        rstn = 1;

        // r3 = 0x11 via writeback
        wb(6'd3, 32'h11); tick(); idle_inputs();

        // ADDI rd=3 rs=r0 imm=0x305, then ADD r4 = r3 + r3
        offer(32'h1000, enc_i(OP_ADDI, 6'd0, 16'h0305)); #1;
        check_f("addi_ready", 32'(bus.if_ready), 32'd1);
        tick();
        check_f("addi_s", bus.de_s, 32'h0);
        check_f("addi_imm", bus.de_imm, 32'h305);
        check_f("addi_start", 32'(bus.de_start), 32'd1);
        offer(32'h1004, enc_r(OP_ADD, 6'd3, 6'd3, 6'd4)); tick();
        check_f("add_s", bus.de_s, 32'h11);
        check_f("add_t", bus.de_t, 32'h11);
        check_f("add_start", 32'(bus.de_start), 32'd1);
        idle_inputs(); tick();
        check_f("idle_start", 32'(bus.de_start), 32'd0);

        // LW r5, then ADDI r6 = r5 + 1 -> one hazard bubble
        offer(32'h2000, enc_i(OP_LW, 6'd1, 16'h0500)); tick();
        check_f("lw_rd", 32'(bus.de_rd), 32'd5);
        offer(32'h2004, enc_i(OP_ADDI, 6'd5, 16'h0601)); #1;
        check_f("lu_ready", 32'(bus.if_ready), 32'd0);
        tick();
        check_f("lu_hazard", 32'(bus.de_hazard), 32'd1);
        check_f("lu_start", 32'(bus.de_start), 32'd0);
        check_f("lu_ready2", 32'(bus.if_ready), 32'd1);
        tick();
        check_f("lu_pc", bus.de_pc, 32'h2004);
        check_f("lu_imm", bus.de_imm, 32'h601);
        check_f("lu_hazard_off", 32'(bus.de_hazard), 32'd0);
        idle_inputs();

        // LW_S f8(=40), then SW reading rt=40 -> bubble
        offer(32'h2100, enc_i(OP_LW_S, 6'd2, 16'h2800)); tick();
        offer(32'h2104, enc_r(OP_SW, 6'd1, 6'd40, 6'd0)); tick();
        check_f("lws_hazard", 32'(bus.de_hazard), 32'd1);
        tick();
        check_f("sw_pc", bus.de_pc, 32'h2104);
        idle_inputs();

        // OUT held by ex_busy for 4 cycles
        offer(32'h3000, enc_i(OP_OUT, 6'd4, 16'h0000)); tick();
        bus.ex_busy = 1;
        offer(32'h3004, enc_r(OP_ADD, 6'd1, 6'd2, 6'd9)); #1;
        check_f("busy_ready", 32'(bus.if_ready), 32'd0);
        check_f("busy_start1", 32'(bus.de_start), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_f("busy_pc", bus.de_pc, 32'h3000);
            check_f("busy_start", 32'(bus.de_start), 32'd0);
        end
        tick();
        bus.ex_busy = 0;
        tick();
        check_f("after_busy_pc", bus.de_pc, 32'h3004);
        check_f("after_busy_start", 32'(bus.de_start), 32'd1);
        idle_inputs();

        // redirect drops word 0x12345678
        offer(32'h4000, 32'h1234_5678); bus.ex_redirect = 1; #1;
        check_f("redir_ready", 32'(bus.if_ready), 32'd1);
        tick();
        check_f("redir_pc", bus.de_pc, 32'h0);
        check_f("redir_instr", 32'(bus.de_instr), 32'd0);
        check_f("redir_start", 32'(bus.de_start), 32'd0);
        idle_inputs(); tick();
        check_f("redir_never", 32'(bus.de_start), 32'd0);

        // same-cycle writeback of r7 and read of r7
        offer(32'h5000, enc_r(OP_ADD, 6'd7, 6'd0, 6'd8));
        wb(6'd7, 32'hDEAD_BEEF); #1;
`ifdef DECODE_REG_BYPASS_EN
        check_f("wb_ready", 32'(bus.if_ready), 32'd1);
        tick();
        check_f("wb_s", bus.de_s, 32'hDEAD_BEEF);
`else
        check_f("wb_ready", 32'(bus.if_ready), 32'd0);
        tick();
        bus.wb_we = 0;
        check_f("wb_hazard", 32'(bus.de_hazard), 32'd1);
        tick();
        check_f("wb_s", bus.de_s, 32'hDEAD_BEEF);
`endif
        check_f("wb_pc", bus.de_pc, 32'h5000);
        idle_inputs();

        // FPR0 (index 32) is a real register, r0 ignores writes
        wb(6'd32, 32'hCAFE_0032); tick();
        wb(6'd0, 32'hFFFF_FFFF); tick(); idle_inputs();
        offer(32'h6000, enc_r(OP_ADD, 6'd32, 6'd0, 6'd9)); tick();
        check_f("fpr0_s", bus.de_s, 32'hCAFE_0032);
        check_f("r0_t", bus.de_t, 32'h0);
        check_f("fpr0_rs", 32'(bus.de_rs), 32'h60);

        // immediate extension and control flags
        offer(32'h7000, enc_j(OP_J, 26'h3AB_CDEF)); tick();
        check_f("j_imm", bus.de_imm, 32'h03AB_CDEF);
        check_f("j_flag", 32'(bus.de_jump), 32'd1);
        offer(32'h7004, enc_i(OP_LUI, 6'd0, 16'h8001)); tick();
        check_f("lui_imm", bus.de_imm, 32'h0000_8001);
        offer(32'h7008, enc_i(OP_ADDI, 6'd0, 16'h8001)); tick();
        check_f("addi_sext", bus.de_imm, 32'hFFFF_8001);
        offer(32'h700C, enc_i(OP_BEQ, 6'd1, 16'hFFFC)); tick();
        check_f("beq_flag", 32'(bus.de_branch), 32'd1);
        offer(32'h7010, enc_r(OP_JR, 6'd32, 6'd0, 6'd0)); tick();
        check_f("jr_flag", 32'(bus.de_is_jr), 32'd1);
        idle_inputs();

        // reset mid-operation
        offer(32'h8000, enc_r(OP_ADD, 6'd7, 6'd32, 6'd10)); tick();
        #2 rstn = 0; #1;
        check_f("mid_rst_pc", bus.de_pc, 32'h0);
        check_f("mid_rst_s", bus.de_s, 32'h0);
        check_f("mid_rst_ready", 32'(bus.if_ready), 32'd0);
        check_f("mid_rst_start", 32'(bus.de_start), 32'd0);
        @(posedge clk); #1;
        rstn = 1;
        tick();
        check_f("rf_cleared_s", bus.de_s, 32'h0);
        check_f("rf_cleared_t", bus.de_t, 32'h0);
        idle_inputs();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
